// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding, flag indices and pass width for the sequential add/sub stage
package alu_pkg;

    localparam int W_BYTE = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_LO   = LO,
        S_HI   = HI,
        S_DONE = DONE
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_addsub_cla8_cin.sv
// rtl/alu_seq_addsub_cla8_cin.sv - 8-bit carry-lookahead add slice with carry in, carry out and signed overflow
module cla8_cin
    import alu_pkg::*;
(
    input  logic [W_BYTE-1:0] a,
    input  logic [W_BYTE-1:0] b,
    input  logic              cin,
    output logic [W_BYTE-1:0] s,
    output logic              cout,
    output logic              overflow
);

    logic [W_BYTE-1:0] p;
    logic [W_BYTE-1:0] g;
    logic [W_BYTE:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products over the generate/propagate terms
    always_comb begin
        logic gen_term;
        logic prop_run;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W_BYTE; i++) begin
            gen_term = 1'b0;
            prop_run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gen_term = gen_term | (prop_run & g[j]);
                prop_run = prop_run & p[j];
            end
            c[i+1] = gen_term | (prop_run & cin);
        end
    end

    assign s        = p ^ c[W_BYTE-1:0];
    assign cout     = c[W_BYTE];
    assign overflow = c[W_BYTE] ^ c[W_BYTE-1];

endmodule

// File: rtl/alu_seq_addsub.sv
// rtl/alu_seq_addsub.sv - two-pass 8/16-bit add/sub execute stage with held result and flags; optional ALU_SEQ_CARRY_IN_EN adds in_cin
module alu_seq_addsub #(
    parameter int W_BYTE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sub,
    input  logic        in_wide,
`ifdef ALU_SEQ_CARRY_IN_EN
    input  logic        in_cin,
`endif
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_res,
    output logic        out_c,
    output logic        out_v,
    output logic        out_n,
    output logic        out_z
);
    import alu_pkg::*;

    state_t              state;
    logic [15:0]         a_q;
    logic [15:0]         b_q;
    logic                sub_q;
    logic                wide_q;
    logic [W_BYTE-1:0]   lo_res;
    logic                lo_c;
    logic                lo_v;
    logic [3:0]          flags_q;

    logic [W_BYTE-1:0]   add_a;
    logic [W_BYTE-1:0]   add_b;
    logic                add_cin;
    logic                lo_cin;
    logic [W_BYTE-1:0]   sum;
    logic                cout;
    logic                ovf;

`ifdef ALU_SEQ_CARRY_IN_EN
    logic                cin_q;
    assign lo_cin = cin_q;
`else
    assign lo_cin = sub_q;
`endif

    // Single adder slice is time-shared: low byte in LO, high byte in HI
    always_comb begin
        logic [W_BYTE-1:0] b_sel;
        if (state == S_HI) begin
            add_a   = a_q[15:8];
            b_sel   = b_q[15:8];
            add_cin = lo_c;
        end else begin
            add_a   = a_q[7:0];
            b_sel   = b_q[7:0];
            add_cin = lo_cin;
        end
        add_b = sub_q ? ~b_sel : b_sel;
    end

    cla8_cin u_cla (
        .a        (add_a),
        .b        (add_b),
        .cin      (add_cin),
        .s        (sum),
        .cout     (cout),
        .overflow (ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= '0;
            flags_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            wide_q    <= 1'b0;
            lo_res    <= '0;
            lo_c      <= 1'b0;
            lo_v      <= 1'b0;
`ifdef ALU_SEQ_CARRY_IN_EN
            cin_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        sub_q    <= in_sub;
                        wide_q   <= in_wide;
`ifdef ALU_SEQ_CARRY_IN_EN
                        cin_q    <= in_cin;
`endif
                        in_ready <= 1'b0;
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    lo_res <= sum;
                    lo_c   <= cout;
                    lo_v   <= ovf;
                    if (wide_q) begin
                        state <= S_HI;
                    end else begin
                        out_res   <= {8'h00, sum};
                        flags_q   <= pack_flags(cout, ovf, sum[W_BYTE-1], sum == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_HI: begin
                    out_res   <= {sum, lo_res};
                    flags_q   <= pack_flags(cout, ovf, sum[W_BYTE-1],
                                            (sum == '0) && (lo_res == '0));
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // Result and flags stay held after the handshake; only out_valid drops
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_c = flags_q[FLAG_C];
    assign out_v = flags_q[FLAG_V];
    assign out_n = flags_q[FLAG_N];
    assign out_z = flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu_seq_addsub.sv
// tb/tb_alu_seq_addsub.sv - self-checking bench for alu_seq_addsub: directed vectors, corner sequences, random ops against an arithmetic model
module tb_alu_seq_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic        in_wide;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_c;
    logic        out_v;
    logic        out_n;
    logic        out_z;

    int checks;
    int errors;

    alu_seq_addsub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_wide   (in_wide),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_n     (out_n),
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        wide;
        logic [15:0] res;
        logic [3:0]  znvc;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the used width
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic wide,
                                  output logic [15:0] r, output logic [3:0] znvc);
        int nb, mask, half, ua, ub, sa, sb, full, sres;
        logic c, v, n, z;
        nb   = wide ? 16 : 8;
        mask = (1 << nb) - 1;
        half = 1 << (nb - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        sa   = (ua >= half) ? ua - (1 << nb) : ua;
        sb   = (ub >= half) ? ub - (1 << nb) : ub;
        if (sub) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full > mask);
            sres = sa + sb;
        end
        v    = (sres < -half) || (sres > half - 1);
        full = full & mask;
        r    = full[15:0];
        n    = full[nb-1];
        z    = (full == 0);
        znvc = {z, n, v, c};
    endfunction

    // Issue one op from IDLE, wait for out_valid, capture, then complete the handshake
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic wide, output logic [15:0] res,
                         output logic [3:0] znvc, output int lat);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_wide  = wide;
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
        end while (!out_valid && lat < 10);
        res  = out_res;
        znvc = {out_z, out_n, out_v, out_c};
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [15:0] res, exp_res, held_res;
        logic [3:0]  znvc, exp_f, held_f;
        int          lat;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_wide   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000, 2};
        vecs[1] = '{16'h0019, 16'h00B1, 1'b1, 1'b0, 16'h0068, 4'b0000, 2};
        vecs[2] = '{16'h007F, 16'h001F, 1'b0, 1'b0, 16'h009E, 4'b0110, 2};
        vecs[3] = '{16'h0081, 16'h0081, 1'b0, 1'b0, 16'h0002, 4'b0011, 2};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 4'b0000, 3};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_res", {16'd0, out_res}, 32'd0);
        chk("rst_flags", {28'd0, out_z, out_n, out_v, out_c}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].wide, res, znvc, lat);
            chk($sformatf("vec%0d_res", i), {16'd0, res}, {16'd0, vecs[i].res});
            chk($sformatf("vec%0d_znvc", i), {28'd0, znvc}, {28'd0, vecs[i].znvc});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Wide subtract to zero: C set (no borrow), Z set
        do_op(16'h1234, 16'h1234, 1'b1, 1'b1, res, znvc, lat);
        chk("wsub_res", {16'd0, res}, 32'h0000);
        chk("wsub_znvc", {28'd0, znvc}, 32'b1001);
        chk("wsub_lat", lat, 3);

        // Backpressure: hold DONE for 5 cycles while a competing request is offered
        @(negedge clk);
        in_a = 16'h0081; in_b = 16'h0081; in_sub = 1'b0; in_wide = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        held_res = out_res;
        held_f   = {out_z, out_n, out_v, out_c};
        chk("bp_res", {16'd0, held_res}, 32'h0002);
        @(negedge clk);
        in_a = 16'h5555; in_b = 16'h1111; in_wide = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_res%0d", k), {16'd0, out_res}, {16'd0, held_res});
            chk($sformatf("bp_hold_f%0d", k), {28'd0, out_z, out_n, out_v, out_c}, {28'd0, held_f});
            chk($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp_out_valid%0d", k), {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_rel_res_held", {16'd0, out_res}, {16'd0, held_res});
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stale_accept", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset while in HI of a wide op
        @(negedge clk);
        in_a = 16'h00FF; in_b = 16'h0001; in_sub = 1'b0; in_wide = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_res", {16'd0, out_res}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_discard", {31'd0, out_valid}, 32'd0);
        do_op(16'h0040, 16'h0040, 1'b0, 1'b0, res, znvc, lat);
        chk("post_rst_res", {16'd0, res}, 32'h0080);
        chk("post_rst_znvc", {28'd0, znvc}, 32'b0110);
        chk("post_rst_lat", lat, 2);

        // Reset concurrent with an accept: reset wins
        @(negedge clk);
        in_a = 16'h0011; in_b = 16'h0022; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_vs_accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vs_accept_noop", {31'd0, out_valid}, 32'd0);

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rs, rw;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rw = 1'($urandom);
            model(ra, rb, rs, rw, exp_res, exp_f);
            do_op(ra, rb, rs, rw, res, znvc, lat);
            chk($sformatf("rnd%0d_res a=%h b=%h s=%0d w=%0d", i, ra, rb, rs, rw), {16'd0, res}, {16'd0, exp_res});
            chk($sformatf("rnd%0d_znvc", i), {28'd0, znvc}, {28'd0, exp_f});
            chk($sformatf("rnd%0d_lat", i), lat, rw ? 3 : 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
